// File: rtl/instr_queue_pkg.sv
// Shared helpers for the multi-port instruction queue: width functions and
// lane-slice offset used by the top and the storage array.
package instr_queue_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Pointer width for a DEPTH-entry ring; pointers wrap naturally modulo DEPTH.
  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction

  // Count must represent 0..DEPTH inclusive, hence one extra code point.
  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

  // Low bit of lane `lane` in a packed multi-lane bus of `width`-bit lanes.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/instr_queue_ram.sv
// DEPTH x INSTR_WIDTH register array with ENQ_W write lanes at consecutive
// addresses and DEQ_W combinational read lanes, all wrapping modulo DEPTH.
module instr_queue_ram
  import instr_queue_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int INSTR_WIDTH = 32,
  parameter int ENQ_W       = 2,
  parameter int DEQ_W       = 2
) (
  input  logic                           clk,
  input  logic [ENQ_W-1:0]               wr_en,
  input  logic [ptr_w(DEPTH)-1:0]        wr_base,
  input  logic [ENQ_W*INSTR_WIDTH-1:0]   wr_data,
  input  logic [ptr_w(DEPTH)-1:0]        rd_base,
  output logic [DEQ_W*INSTR_WIDTH-1:0]   rd_data
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; stale entries are never
  // observable because the top masks read lanes with the registered count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_W; i++) begin
      if (wr_en[i]) begin
        mem[wr_base + PTR_W'(i)] <= wr_data[lane_lo(i, INSTR_WIDTH) +: INSTR_WIDTH];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < DEQ_W; k++) begin
      rd_data[lane_lo(k, INSTR_WIDTH) +: INSTR_WIDTH] = mem[rd_base + PTR_W'(k)];
    end
  end

endmodule

// File: rtl/instr_queue_mp.sv
// Multi-port in-order instruction queue: up to ENQ_W enqueues and DEQ_W
// variable-count dequeues per cycle, with flush and protocol-error pulse.
module instr_queue_mp
  import instr_queue_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int INSTR_WIDTH  = 32,
  parameter int ENQ_W        = 2,
  parameter int DEQ_W        = 2,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic [ENQ_W-1:0]               enq_valid,
  input  logic [ENQ_W*INSTR_WIDTH-1:0]   enq_instr,
  output logic                           enq_ready,
  output logic [DEQ_W-1:0]               deq_valid,
  output logic [DEQ_W*INSTR_WIDTH-1:0]   deq_instr,
  input  logic [clog2(DEQ_W+1)-1:0]      deq_take,
  output logic [cnt_w(DEPTH)-1:0]        count,
  output logic                           full,
  output logic                           empty,
  output logic                           almost_full,
  output logic                           err
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  localparam logic [CNT_W-1:0] ENQ_LIMIT = CNT_W'(DEPTH - ENQ_W);
  localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] DEPTH_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEQ_LANES = CNT_W'(DEQ_W);

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  logic [CNT_W-1:0] n_enq;
  logic [CNT_W-1:0] n_enq_acc;
  logic [CNT_W-1:0] n_deq;
  logic [CNT_W-1:0] avail;
  logic [CNT_W-1:0] take_ext;
  logic             thermo;
  logic             enq_any;
  logic             enq_ok;
  logic             enq_bad;
  logic             deq_over;
  logic [ENQ_W-1:0] wr_en;

  logic [DEQ_W*INSTR_WIDTH-1:0] rd_data;

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    n_enq  = '0;
    thermo = 1'b1;
    for (int i = 0; i < ENQ_W; i++) begin
      if (enq_valid[i]) n_enq = n_enq + 1'b1;
    end
    // A valid lane above an idle lane breaks the lane-0-first ordering.
    for (int i = 1; i < ENQ_W; i++) begin
      if (enq_valid[i] && !enq_valid[i-1]) thermo = 1'b0;
    end
  end

  assign enq_ready = (count <= ENQ_LIMIT);
  assign enq_any   = |enq_valid;
  assign enq_ok    = enq_any && thermo && enq_ready && !flush;
  assign enq_bad   = enq_any && !(thermo && enq_ready);
  assign n_enq_acc = enq_ok ? n_enq : '0;
  assign wr_en     = enq_ok ? enq_valid : '0;

  // Dequeue count is clamped to what is actually presented on the lanes.
  assign avail    = (count > DEQ_LANES) ? DEQ_LANES : count;
  assign take_ext = CNT_W'(deq_take);
  assign deq_over = (take_ext > avail);
  assign n_deq    = flush ? '0 : (deq_over ? avail : take_ext);

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      head  <= head + PTR_W'(n_deq);
      tail  <= tail + PTR_W'(n_enq_acc);
      count <= count + n_enq_acc - n_deq;
      err   <= enq_bad || deq_over;
    end
  end

  instr_queue_ram #(
    .DEPTH       (DEPTH),
    .INSTR_WIDTH (INSTR_WIDTH),
    .ENQ_W       (ENQ_W),
    .DEQ_W       (DEQ_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_base (tail),
    .wr_data (enq_instr),
    .rd_base (head),
    .rd_data (rd_data)
  );

  always_comb begin
    deq_valid = '0;
    deq_instr = '0;
    for (int k = 0; k < DEQ_W; k++) begin
      deq_valid[k] = (count > CNT_W'(k));
      if (deq_valid[k]) begin
        deq_instr[lane_lo(k, INSTR_WIDTH) +: INSTR_WIDTH] =
          rd_data[lane_lo(k, INSTR_WIDTH) +: INSTR_WIDTH];
      end
    end
  end

  assign full        = (count == DEPTH_LVL);
  assign empty       = (count == '0);
  assign almost_full = (count >= AFULL_LVL);

endmodule

// File: doc/instr_queue_mp.md
# instr_queue_mp

Multi-port, parametrised instruction queue between fetch/decode and reservation-station dispatch in the out-of-order core. Each cycle it accepts up to ENQ_W in-order instructions and presents up to DEQ_W oldest instructions, with variable-count dequeue, exact occupancy count, almost-full back-pressure and single-cycle flush for branch mispredict recovery. It generalises the single-lane circular instruction buffer to wider issue.

## Interface
- DEPTH, 16: entries; power of two, ≥ 2·max(ENQ_W, DEQ_W)
- INSTR_WIDTH, 32: instruction bits
- ENQ_W, 2: enqueue lanes
- DEQ_W, 2: dequeue lanes
- AFULL_THRESH, DEPTH-4: almost_full asserts when count ≥ this
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  discard all contents this cycle
- enq_valid  in  ENQ_W  lane valids; must be thermometer (lane 0 first)
- enq_instr  in  ENQ_W·INSTR_WIDTH  lane i at bits [i·INSTR_WIDTH +: INSTR_WIDTH]
- enq_ready  out  1  free entries ≥ ENQ_W
- deq_valid  out  DEQ_W  lane k holds the k-th oldest entry
- deq_instr  out  DEQ_W·INSTR_WIDTH  oldest entry on lane 0; zero on invalid lanes
- deq_take  in  clog2(DEQ_W+1)  number of lanes consumed this cycle
- count  out  clog2(DEPTH+1)  current occupancy
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_THRESH
- err  out  1  one-cycle pulse on protocol violation

## Operation
- Storage: DEPTH-entry array; head, tail are clog2(DEPTH)-bit pointers, wrap naturally (modulo DEPTH); count held as separate register.
- Enqueue: n_enq = popcount(enq_valid) accepted all-or-nothing when enq_ready=1; entry lane i written at tail+i; tail += n_enq.
- enq_valid with n_enq>0 while enq_ready=0: nothing written, err pulses.
- Non-thermometer enq_valid: treated as error, nothing written, err pulses.
- Dequeue: deq_valid[k] = (count > k); deq_instr lane k = mem[head+k] (combinational read). n_deq = min(deq_take, count, DEQ_W); head += n_deq.
- deq_take > number of valid lanes: clamp as above, err pulses.
- Simultaneous enq/deq: count_next = count + n_enq − n_deq; enq_ready computed from current count only (no same-cycle bypass of freed space).
- flush: head, tail, count ← 0; same-cycle enqueue and dequeue ignored; err not raised.
- Reset: head, tail, count ← 0; err ← 0; array contents need not be cleared (deq_instr masked to zero by deq_valid).
- Reset-state outputs: enq_ready=1, deq_valid=0, deq_instr=0, count=0, full=0, empty=1, almost_full=0, err=0.

## Timing
- Enqueue-to-visible latency 1 cycle: instruction written at edge N appears on deq lanes during cycle N+1.
- Dequeue is same-cycle: consumer samples deq_instr and drives deq_take in the same cycle; head advances at the edge.
- count, full, empty, almost_full, enq_ready derive from registered count; no combinational path from enq_valid or deq_take to any of them.
- deq_instr/deq_valid depend combinationally on head/count only, not on deq_take.
- err is registered, asserted the cycle after the violating edge, for one cycle.
- Reset asserted mid-operation clears state asynchronously; flush is synchronous.

## Structure
- Shared package/header instr_queue_pkg: clog2 function, pointer/count width constants, lane-slice macro.
- Sub-module instr_queue_ram: DEPTH×INSTR_WIDTH register array, ENQ_W write ports, DEQ_W combinational read ports at consecutive addresses with wrap.
- Top holds pointers, count, flag and err logic.

## Test plan
- Reset, enqueue 2 instr (0x11,0x22) with deq_take=0 -> next cycle count=2, deq_valid=2'b11, lane0=0x11, lane1=0x22.
- Fill DEPTH=16 with 8 pairs, no dequeue -> count=16, full=1, enq_ready=0 at count=15; further enq_valid=2'b11 gives err pulse, count unchanged.
- Steady state: enqueue 2, deq_take=2 every cycle across ≥3 wraps -> count constant, dequeue order identical to enqueue order.
- count=1, deq_take=2 with enq_valid=2'b01 -> n_deq=1, err pulses, next count=1 holding the new instr.
- count=10, flush with enq_valid=2'b11 -> next cycle count=0, empty=1, deq_valid=0, err=0.
- Assert reset mid-fill (count=7) without clock edge -> outputs return to reset values immediately; first post-reset enqueue lands on lane 0.
